// File: rtl/mini_src_pkg.sv
// Shared types and encodings for the Mini-SRC hardwired control unit.
// CU_SINGLE_STEP_EN adds the STEP_WAIT state used by single-step builds.
package mini_src_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_HALT
`ifdef CU_SINGLE_STEP_EN
    , S_STEP_WAIT
`endif
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU3,
    CLS_UNARY,
    CLS_MULDIV,
    CLS_NOP,
    CLS_HALT,
    CLS_ILLEGAL
  } op_class_t;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_SHR  = 4'd4;
  localparam logic [3:0] ALU_SHRA = 4'd5;
  localparam logic [3:0] ALU_SHL  = 4'd6;
  localparam logic [3:0] ALU_ROR  = 4'd7;
  localparam logic [3:0] ALU_ROL  = 4'd8;
  localparam logic [3:0] ALU_MUL  = 4'd9;
  localparam logic [3:0] ALU_DIV  = 4'd10;
  localparam logic [3:0] ALU_NEG  = 4'd11;
  localparam logic [3:0] ALU_NOT  = 4'd12;
  localparam logic [3:0] ALU_NONE = 4'd15;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int RA_HI  = 26;
  localparam int RA_LO  = 23;
  localparam int RB_HI  = 22;
  localparam int RB_LO  = 19;
  localparam int RC_HI  = 18;
  localparam int RC_LO  = 15;

endpackage

// File: rtl/op_decode.sv
// Combinational opcode decoder: instruction class plus the ALU function it needs.
module op_decode
  import mini_src_pkg::*;
#(
  parameter int OPW  = 5,
  parameter int ALUW = 4
) (
  input  logic [OPW-1:0]  opcode,
  output op_class_t       op_class,
  output logic [ALUW-1:0] alu_op
);

  always_comb begin
    op_class = CLS_ILLEGAL;
    alu_op   = ALUW'(ALU_NONE);
    case (opcode)
      OPW'(OP_ADD):  begin op_class = CLS_ALU3;   alu_op = ALUW'(ALU_ADD);  end
      OPW'(OP_SUB):  begin op_class = CLS_ALU3;   alu_op = ALUW'(ALU_SUB);  end
      OPW'(OP_SHR):  begin op_class = CLS_ALU3;   alu_op = ALUW'(ALU_SHR);  end
      OPW'(OP_SHRA): begin op_class = CLS_ALU3;   alu_op = ALUW'(ALU_SHRA); end
      OPW'(OP_SHL):  begin op_class = CLS_ALU3;   alu_op = ALUW'(ALU_SHL);  end
      OPW'(OP_ROR):  begin op_class = CLS_ALU3;   alu_op = ALUW'(ALU_ROR);  end
      OPW'(OP_ROL):  begin op_class = CLS_ALU3;   alu_op = ALUW'(ALU_ROL);  end
      OPW'(OP_AND):  begin op_class = CLS_ALU3;   alu_op = ALUW'(ALU_AND);  end
      OPW'(OP_OR):   begin op_class = CLS_ALU3;   alu_op = ALUW'(ALU_OR);   end
      OPW'(OP_MUL):  begin op_class = CLS_MULDIV; alu_op = ALUW'(ALU_MUL);  end
      OPW'(OP_DIV):  begin op_class = CLS_MULDIV; alu_op = ALUW'(ALU_DIV);  end
      OPW'(OP_NEG):  begin op_class = CLS_UNARY;  alu_op = ALUW'(ALU_NEG);  end
      OPW'(OP_NOT):  begin op_class = CLS_UNARY;  alu_op = ALUW'(ALU_NOT);  end
      OPW'(OP_NOP):  op_class = CLS_NOP;
      OPW'(OP_HALT): op_class = CLS_HALT;
      default:       op_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Mini-SRC hardwired control sequencer: fetch/execute T-states driving datapath strobes.
// CU_SINGLE_STEP_EN adds a step input and a STEP_WAIT state between instructions.
//
// state     | meaning
// IDLE      | waiting for start, all strobes low
// T0..T2    | fetch: PC->MAR, memory read into MDR, MDR->IR
// T3..T6    | execute, length depends on instruction class
// HALT      | halt or illegal opcode, left only by clear
// STEP_WAIT | single-step builds: parked between instructions until step
module control_unit
  import mini_src_pkg::*;
#(
  parameter int OPW  = 5,
  parameter int ALUW = 4
) (
  input  logic            Clock,
  input  logic            clear,
  input  logic            start,
  input  logic            mem_ready,
`ifdef CU_SINGLE_STEP_EN
  input  logic            step,
`endif
  input  logic [31:0]     ir,
  output logic            PCout,
  output logic            Zlowout,
  output logic            Zhighout,
  output logic            MDRout,
  output logic            MARin,
  output logic            Zin,
  output logic            PCin,
  output logic            MDRin,
  output logic            IRin,
  output logic            Yin,
  output logic            LOin,
  output logic            HIin,
  output logic            IncPC,
  output logic            Read,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            Rin,
  output logic            Rout,
  output logic [ALUW-1:0] alu_op,
  output logic            run,
  output logic            illegal_op
);

  state_t          state;
  logic            illegal_q;
  op_class_t       op_class;
  logic [ALUW-1:0] dec_alu;
  state_t          done_state;

  // Only the opcode steers sequencing; register fields go straight to the datapath.
  logic unused_ir;
  assign unused_ir = ^{ir[RA_HI:RA_LO], ir[RB_HI:RB_LO], ir[RC_HI:RC_LO], ir[RC_LO-1:0]};

  op_decode #(.OPW(OPW), .ALUW(ALUW)) u_op_decode (
    .opcode   (ir[OPC_HI -: OPW]),
    .op_class (op_class),
    .alu_op   (dec_alu)
  );

`ifdef CU_SINGLE_STEP_EN
  assign done_state = S_STEP_WAIT;
`else
  assign done_state = S_T0;
`endif

  always_ff @(posedge Clock) begin
    if (clear) begin
      state     <= S_IDLE;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) state <= S_T0;
        S_T0:   state <= S_T1;
        S_T1:   if (mem_ready) state <= S_T2;
        S_T2: begin
          case (op_class)
            CLS_NOP:     state <= S_T0;
            CLS_HALT:    state <= S_HALT;
            CLS_ILLEGAL: begin
              state     <= S_HALT;
              illegal_q <= 1'b1;
            end
            default:     state <= S_T3;
          endcase
        end
        S_T3:   state <= S_T4;
        S_T4:   state <= (op_class == CLS_UNARY) ? done_state : S_T5;
        S_T5:   state <= (op_class == CLS_MULDIV) ? S_T6 : done_state;
        S_T6:   state <= done_state;
        S_HALT: state <= S_HALT;
`ifdef CU_SINGLE_STEP_EN
        S_STEP_WAIT: if (step) state <= S_T0;
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    PCout    = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    MDRout   = 1'b0;
    MARin    = 1'b0;
    Zin      = 1'b0;
    PCin     = 1'b0;
    MDRin    = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    LOin     = 1'b0;
    HIin     = 1'b0;
    IncPC    = 1'b0;
    Read     = 1'b0;
    Gra      = 1'b0;
    Grb      = 1'b0;
    Grc      = 1'b0;
    Rin      = 1'b0;
    Rout     = 1'b0;
    alu_op   = ALUW'(ALU_NONE);
    if (!clear) begin
      case (state)
        S_T0: begin
          PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
        end
        S_T1: begin
          Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
        end
        S_T2: begin
          MDRout = 1'b1; IRin = 1'b1;
        end
        S_T3: begin
          Rout = 1'b1;
          case (op_class)
            CLS_UNARY:  begin Grb = 1'b1; Zin = 1'b1; alu_op = dec_alu; end
            CLS_MULDIV: begin Gra = 1'b1; Yin = 1'b1; end
            default:    begin Grb = 1'b1; Yin = 1'b1; end
          endcase
        end
        S_T4: begin
          case (op_class)
            CLS_UNARY: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            CLS_MULDIV: begin
              Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = dec_alu;
            end
            default: begin
              Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = dec_alu;
            end
          endcase
        end
        S_T5: begin
          Zlowout = 1'b1;
          if (op_class == CLS_MULDIV) LOin = 1'b1;
          else begin Gra = 1'b1; Rin = 1'b1; end
        end
        S_T6: begin
          Zhighout = 1'b1; HIin = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign run        = !clear && (state != S_IDLE) && (state != S_HALT);
  assign illegal_op = !clear && illegal_q;

endmodule
